// File: rtl/mips_trace_buffer.sv
// Debug trace FIFO behind the single-cycle MIPS core: captures {seq, PC, ULA, DMEM}
// records per enabled cycle and drains them over a valid/ready handshake.
module mips_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              capture_en,
  input  logic [31:0]       current_PC,
  input  logic [31:0]       ULA_result,
  input  logic [31:0]       d_mem_out,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_ula,
  output logic [31:0]       out_dmem,
  output logic [15:0]       out_seq,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [15:0]       drop_count
);

  localparam int                REC_W    = 112;
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [REC_W-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [15:0]       seq_q, seq_d;
  logic [15:0]       drop_count_q, drop_count_d;
  logic              overflow_q, overflow_d;
  logic              empty, full, pop, push_try, push_ok, drop;
  logic [REC_W-1:0]  wr_rec, head;

  always_comb begin
    empty        = (count_q == '0);
    full         = (count_q == FULL_CNT);
    pop          = !empty && out_ready && !clear;
    push_try     = capture_en && !clear;
    // A full FIFO still accepts when the head leaves on the same edge.
    push_ok      = push_try && (!full || pop);
    drop         = push_try && full && !pop;
    wr_rec       = {seq_q, current_PC, ULA_result, d_mem_out};
    seq_d        = capture_en ? seq_q + 16'd1 : seq_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push_ok && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push_ok) count_d = count_q - CNT_ONE;
      if (drop) begin
        overflow_d   = 1'b1;
        drop_count_d = sat_inc16(drop_count_q);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok && !reset) mem_q[wr_ptr_q] <= wr_rec;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      seq_q        <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      seq_q        <= seq_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  always_comb begin
    head = mem_q[rd_ptr_q];
    {out_seq, out_pc, out_ula, out_dmem} = empty ? '0 : head;
  end

  assign out_valid  = !empty;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Bench for mips_trace_buffer: vector table plus a queue scoreboard tracking FIFO contents.
module tb_mips_trace_buffer;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clock = 1'b0;
  logic              reset, capture_en, clear, out_ready;
  logic [31:0]       current_PC, ULA_result, d_mem_out;
  logic              out_valid;
  logic [31:0]       out_pc, out_ula, out_dmem;
  logic [15:0]       out_seq, drop_count;
  logic [ADDR_W:0]   count;
  logic              overflow;

  mips_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .capture_en(capture_en),
    .current_PC(current_PC), .ULA_result(ULA_result), .d_mem_out(d_mem_out),
    .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_ula(out_ula), .out_dmem(out_dmem), .out_seq(out_seq),
    .count(count), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ula;
    logic [31:0] dm;
    logic [15:0] seq;
  } rec_t;

  typedef struct {
    logic        cap;
    logic [31:0] pc;
    logic        rdy;
    logic [4:0]  e_cnt;
    logic        e_vld;
    logic [31:0] e_pc;
    logic [15:0] e_seq;
  } vec_t;

  rec_t        sb[$];
  logic [15:0] m_seq  = '0;
  logic [15:0] m_drop = '0;
  logic        m_ovf  = 1'b0;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_state();
    chk("count", 64'(count), 64'(sb.size()));
    chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_count", 64'(drop_count), 64'(m_drop));
    if (sb.size() != 0) begin
      chk("out_pc", 64'(out_pc), 64'(sb[0].pc));
      chk("out_ula", 64'(out_ula), 64'(sb[0].ula));
      chk("out_dmem", 64'(out_dmem), 64'(sb[0].dm));
      chk("out_seq", 64'(out_seq), 64'(sb[0].seq));
    end else begin
      chk("out_pc_empty", 64'(out_pc), 64'd0);
      chk("out_ula_empty", 64'(out_ula), 64'd0);
      chk("out_dmem_empty", 64'(out_dmem), 64'd0);
      chk("out_seq_empty", 64'(out_seq), 64'd0);
    end
  endtask

  // Called at a falling edge; drives one cycle, updates the scoreboard, samples at the next falling edge.
  task automatic step(input logic cap, input logic [31:0] pc, input logic rdy,
                      input logic clr, input logic rst, input bit do_chk);
    rec_t r;
    bit   pop;
    bit   acc;
    capture_en = cap;
    current_PC = pc;
    ULA_result = $urandom;
    d_mem_out  = $urandom;
    out_ready  = rdy;
    clear      = clr;
    reset      = rst;
    @(posedge clock);
    acc = 1'b0;
    if (rst) begin
      sb.delete();
      m_seq = '0; m_ovf = 1'b0; m_drop = '0;
    end else if (clr) begin
      sb.delete();
      m_ovf = 1'b0; m_drop = '0;
      if (cap) m_seq++;
    end else begin
      pop = rdy && (sb.size() != 0);
      if (cap) begin
        if (sb.size() < DEPTH || pop) begin
          acc = 1'b1;
          r.pc = pc; r.ula = ULA_result; r.dm = d_mem_out; r.seq = m_seq;
        end else begin
          m_ovf = 1'b1;
          if (m_drop != 16'hFFFF) m_drop++;
        end
        m_seq++;
      end
      if (pop) void'(sb.pop_front());
      if (acc) sb.push_back(r);
    end
    @(negedge clock);
    capture_en = 1'b0;
    out_ready  = 1'b0;
    clear      = 1'b0;
    reset      = 1'b0;
    if (do_chk) check_state();
  endtask

  initial begin
    vec_t tbl[7];
    tbl[0] = '{1'b1, 32'h0, 1'b0, 5'd1, 1'b1, 32'h0, 16'd0};
    tbl[1] = '{1'b1, 32'h4, 1'b0, 5'd2, 1'b1, 32'h0, 16'd0};
    tbl[2] = '{1'b1, 32'h8, 1'b0, 5'd3, 1'b1, 32'h0, 16'd0};
    tbl[3] = '{1'b0, 32'h0, 1'b1, 5'd2, 1'b1, 32'h4, 16'd1};
    tbl[4] = '{1'b0, 32'h0, 1'b1, 5'd1, 1'b1, 32'h8, 16'd2};
    tbl[5] = '{1'b0, 32'h0, 1'b1, 5'd0, 1'b0, 32'h0, 16'd0};
    tbl[6] = '{1'b0, 32'h0, 1'b1, 5'd0, 1'b0, 32'h0, 16'd0};

    reset = 1'b1; capture_en = 1'b0; clear = 1'b0; out_ready = 1'b0;
    current_PC = '0; ULA_result = '0; d_mem_out = '0;
    @(negedge clock);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 7; i++) begin
      step(tbl[i].cap, tbl[i].pc, tbl[i].rdy, 1'b0, 1'b0, 1'b1);
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(tbl[i].e_cnt));
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(tbl[i].e_vld));
      chk($sformatf("vec%0d_pc", i), 64'(out_pc), 64'(tbl[i].e_pc));
      chk($sformatf("vec%0d_seq", i), 64'(out_seq), 64'(tbl[i].e_seq));
    end

    // Overflow: 18 captures into 16 entries, drain, then check seq gap.
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 18; i++) step(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_count", 64'(count), 64'd16);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_drops", 64'(drop_count), 64'd2);
    for (int i = 0; i < 16; i++) begin
      chk("drain_seq", 64'(out_seq), 64'(i));
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    chk("drained_count", 64'(count), 64'd0);
    step(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("seq_after_drop", 64'(out_seq), 64'd18);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 15; i++) step(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b1);
    chk("full_count", 64'(count), 64'd16);
    step(1'b1, 32'hCAFE0000, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("pushpop_count", 64'(count), 64'd16);
    chk("pushpop_drops", 64'(drop_count), 64'd2);
    for (int i = 0; i < 15; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("tail_pc", 64'(out_pc), 64'hCAFE0000);
    chk("tail_seq", 64'(out_seq), 64'd34);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Drop counter saturation and seq wrap.
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 32'h400 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 65540; i++) step(1'b1, 32'h480, 1'b0, 1'b0, 1'b0, (i % 8192) == 0);
    chk("sat_drops", 64'(drop_count), 64'hFFFF);
    chk("sat_ovf", 64'(overflow), 64'd1);
    for (int i = 0; i < 16; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("wrapped_seq", 64'(out_seq), 64'd20);
    chk("sat_drops_hold", 64'(drop_count), 64'hFFFF);

    // Clear with count=5 and overflow set, then reset mid-drain.
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 17; i++) step(1'b1, 32'h600 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("pre_clear_count", 64'(count), 64'd5);
    chk("pre_clear_ovf", 64'(overflow), 64'd1);
    step(1'b1, 32'h700, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("clear_count", 64'(count), 64'd0);
    chk("clear_ovf", 64'(overflow), 64'd0);
    chk("clear_drops", 64'(drop_count), 64'd0);
    step(1'b1, 32'h704, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("seq_kept_by_clear", 64'(out_seq), 64'd18);
    for (int i = 0; i < 7; i++) step(1'b1, 32'h708 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("mid_drain_count", 64'(count), 64'd7);
    step(1'b1, 32'h800, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_seq", 64'(out_seq), 64'd0);
    step(1'b1, 32'h900, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("seq_restart", 64'(out_seq), 64'd0);
    chk("seq_restart_pc", 64'(out_pc), 64'h900);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
